// File: rtl/instr_issue.sv
// rtl/instr_issue.sv - fetch-and-issue unit: fetch FSM, 2-entry decoded instruction queue (ISSUE_ILLEGAL_TRAP_EN adds HALT on illegal push)
module instr_issue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        issue_valid,
   input  logic        issue_ready,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        r_type,
   output logic        i_type,
   output logic        store,
   output logic [2:0]  func3,
   output logic [6:0]  fun7,
   output logic        illegal,
   input  logic        flush,
   input  logic [31:0] flush_pc
);

`ifdef ISSUE_ILLEGAL_TRAP_EN
   typedef enum logic [1:0] {IDLE, FETCH, STALL, HALT} state_t;
`else
   typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;
`endif

   state_t      state, state_nx;
   logic [31:0] fetch_pc;
   logic [31:0] q_instr [2];
   logic [31:0] q_pc    [2];
   logic [3:0]  q_flags [2];   // {illegal, store, i_type, r_type}
   logic        wr_ptr, rd_ptr;
   logic [1:0]  count, cnt_after;
   logic        push, pop;
   logic        d_r, d_i, d_s, d_ill;
   logic [3:0]  d_flags;
   logic        head_from_push;
   logic        head_idx;

   // Classify the word arriving from memory so the flags are stored with the entry
   always_comb begin
      d_r     = (imem_rdata[6:0] == 7'b0110011);
      d_i     = (imem_rdata[6:0] == 7'b0010011) || (imem_rdata[6:0] == 7'b0000011);
      d_s     = (imem_rdata[6:0] == 7'b0100011);
      d_ill   = ~(d_r | d_i | d_s);
      d_flags = {d_ill, d_s, d_i, d_r};
   end

   assign imem_req    = (state == FETCH);
   assign imem_addr   = fetch_pc;
   assign issue_valid = (count != 2'd0);

   // Flush suppresses both the push and the pop of its cycle
   assign push      = (state == FETCH) & imem_ack & ~flush;
   assign pop       = issue_valid & issue_ready & ~flush;
   assign cnt_after = count + {1'b0, push} - {1'b0, pop};

   // Head after this cycle is the pushed word when the queue would otherwise be empty
   assign head_from_push = (count == {1'b0, pop});
   assign head_idx       = rd_ptr ^ pop;

   // Next-state logic; flush overrides every state
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  state_nx = FETCH;
         FETCH: begin
            if (push) begin
`ifdef ISSUE_ILLEGAL_TRAP_EN
               if (d_ill)
                  state_nx = HALT;
               else
`endif
               if (cnt_after == 2'd2)
                  state_nx = STALL;
            end
         end
         STALL: if ((count != 2'd2) || pop) state_nx = FETCH;
`ifdef ISSUE_ILLEGAL_TRAP_EN
         HALT:  state_nx = HALT;
`endif
         default: state_nx = IDLE;
      endcase
      if (flush)
         state_nx = FETCH;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Fetch PC: redirect is word-aligned, sequential fetch wraps naturally at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fetch_pc <= RESET_PC;
      else if (flush)
         fetch_pc <= {flush_pc[31:2], 2'b00};
      else if (push)
         fetch_pc <= fetch_pc + 32'd4;
   end

   // Circular queue storage and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         for (int k = 0; k < 2; k++) begin
            q_instr[k] <= '0;
            q_pc[k]    <= '0;
            q_flags[k] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= fetch_pc;
            q_flags[wr_ptr] <= d_flags;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= cnt_after;
      end
   end

   // Registered head outputs; they hold their last value while the queue is empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr   <= '0;
         pc      <= '0;
         func3   <= '0;
         fun7    <= '0;
         {illegal, store, i_type, r_type} <= 4'b0000;
      end else if (!flush && (cnt_after != 2'd0)) begin
         if (head_from_push) begin
            instr <= imem_rdata;
            pc    <= fetch_pc;
            func3 <= imem_rdata[14:12];
            fun7  <= imem_rdata[31:25];
            {illegal, store, i_type, r_type} <= d_flags;
         end else begin
            instr <= q_instr[head_idx];
            pc    <= q_pc[head_idx];
            func3 <= q_instr[head_idx][14:12];
            fun7  <= q_instr[head_idx][31:25];
            {illegal, store, i_type, r_type} <= q_flags[head_idx];
         end
      end
   end

endmodule
